// File: rtl/instr_register_pkg.sv
// rtl/instr_register_pkg.sv - instruction register types shared by the register and its execution sequencer
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic signed [63:0] result_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  result;
    } instruction_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        DIVW  = 3'd3,
        OUT   = 3'd4,
        DONE  = 3'd5
    } exec_state_t;

    localparam int DIV_CYCLES = 32;

endpackage

// File: rtl/instr_exec_div.sv
// rtl/instr_exec_div.sv - restoring signed divider on magnitudes, one quotient bit per cycle
module instr_exec_div #(
    parameter int STEPS = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic signed [31:0] dividend,
    input  logic signed [31:0] divisor,
    output logic               done,
    output logic signed [63:0] quotient,
    output logic signed [63:0] remainder
);

    localparam int CW = $clog2(STEPS + 1);

    logic [31:0]   rem, quo, dvs;
    logic [31:0]   abs_a, abs_b;
    logic [31:0]   src_rem, src_quo, src_dvs;
    logic [31:0]   rem_nxt, quo_nxt;
    logic [32:0]   shifted, diff;
    logic [63:0]   q_mag, r_mag;
    logic          neg_q, neg_r, running;
    logic [CW-1:0] cnt;

    assign abs_a = dividend[31] ? (~dividend + 32'd1) : dividend;
    assign abs_b = divisor[31]  ? (~divisor + 32'd1)  : divisor;

    // The first step runs in the start cycle straight from the operands,
    // so the result is registered after exactly STEPS edges.
    always_comb begin
        src_rem = start ? 32'd0 : rem;
        src_quo = start ? abs_a : quo;
        src_dvs = start ? abs_b : dvs;
        shifted = {src_rem, src_quo[31]};
        diff    = shifted - {1'b0, src_dvs};
        rem_nxt = shifted[31:0];
        quo_nxt = {src_quo[30:0], 1'b0};
        if (shifted >= {1'b0, src_dvs}) begin
            rem_nxt = diff[31:0];
            quo_nxt = {src_quo[30:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            running <= 1'b0;
            cnt     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem     <= rem_nxt;
                quo     <= quo_nxt;
                dvs     <= abs_b;
                neg_q   <= dividend[31] ^ divisor[31];
                neg_r   <= dividend[31];
                cnt     <= CW'(1);
                running <= 1'b1;
            end else if (running) begin
                rem <= rem_nxt;
                quo <= quo_nxt;
                cnt <= cnt + CW'(1);
                if (cnt == CW'(STEPS - 1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign q_mag     = {32'd0, quo};
    assign r_mag     = {32'd0, rem};
    assign quotient  = neg_q ? (~q_mag + 64'd1) : q_mag;
    assign remainder = neg_r ? (~r_mag + 64'd1) : r_mag;

endmodule

// File: rtl/instr_exec_seq.sv
// rtl/instr_exec_seq.sv - walks a register address range, executes each instruction, streams results
module instr_exec_seq
    import instr_register_pkg::*;
#(
    parameter int DIV_CYCLES = instr_register_pkg::DIV_CYCLES
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  address_t     first_addr,
    input  address_t     last_addr,
    output address_t     read_pointer,
    input  instruction_t instruction_word,
    output logic         result_valid,
    input  logic         result_ready,
    output result_t      result,
    output address_t     result_addr,
    output opcode_t      result_opc,
    output logic         result_err,
    output logic         busy,
    output logic         done
);

    exec_state_t state;
    address_t    ptr, last;
    opcode_t     opc;
    operand_t    op_a, op_b;
    result_t     a64, b64, alu_res, div_q, div_r;
    logic        alu_err, is_div, div_zero, div_start, div_done;
    logic        unused_result_field;

    assign unused_result_field = ^instruction_word.result;

    assign a64       = {{32{op_a[31]}}, op_a};
    assign b64       = {{32{op_b[31]}}, op_b};
    assign is_div    = (opc == DIV) || (opc == MOD);
    assign div_zero  = (op_b == '0);
    assign div_start = (state == EXEC) && is_div && !div_zero;

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (opc)
            ZERO:     alu_res = '0;
            PASSA:    alu_res = a64;
            PASSB:    alu_res = b64;
            ADD:      alu_res = a64 + b64;
            SUB:      alu_res = a64 - b64;
            MULT:     alu_res = a64 * b64;
            // Only the divide-by-zero case reaches the ALU result path.
            DIV, MOD: alu_err = 1'b1;
            default:  alu_err = 1'b1;
        endcase
    end

    instr_exec_div #(
        .STEPS(DIV_CYCLES)
    ) u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (div_start),
        .dividend (op_a),
        .divisor  (op_b),
        .done     (div_done),
        .quotient (div_q),
        .remainder(div_r)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            ptr          <= '0;
            last         <= '0;
            opc          <= ZERO;
            op_a         <= '0;
            op_b         <= '0;
            read_pointer <= '0;
            result_valid <= 1'b0;
            result       <= '0;
            result_addr  <= '0;
            result_opc   <= ZERO;
            result_err   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr          <= first_addr;
                        last         <= last_addr;
                        read_pointer <= first_addr;
                        busy         <= 1'b1;
                        state        <= FETCH;
                    end
                end
                FETCH: begin
                    opc   <= instruction_word.opc;
                    op_a  <= instruction_word.op_a;
                    op_b  <= instruction_word.op_b;
                    state <= EXEC;
                end
                EXEC: begin
                    if (is_div && !div_zero) begin
                        state <= DIVW;
                    end else begin
                        result       <= alu_res;
                        result_err   <= alu_err;
                        result_addr  <= ptr;
                        result_opc   <= opc;
                        result_valid <= 1'b1;
                        state        <= OUT;
                    end
                end
                DIVW: begin
                    if (div_done) begin
                        result       <= (opc == MOD) ? div_r : div_q;
                        result_err   <= 1'b0;
                        result_addr  <= ptr;
                        result_opc   <= opc;
                        result_valid <= 1'b1;
                        state        <= OUT;
                    end
                end
                OUT: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        if (ptr == last) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            ptr          <= ptr + address_t'(1);
                            read_pointer <= ptr + address_t'(1);
                            state        <= FETCH;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
